// File: rtl/sample_packer_if.sv
// sample_packer_if: sample stream in, packed word stream out
interface sample_packer_if;
  logic        In_valid;
  logic        In_ready;
  logic [9:0]  In_data;
  logic        In_last;
  logic        Out_valid;
  logic        Out_ready;
  logic [31:0] Out_data;
  modport master (
    output In_valid, In_data, In_last, Out_ready,
    input  In_ready, Out_valid, Out_data
  );
  modport slave (
    input  In_valid, In_data, In_last, Out_ready,
    output In_ready, Out_valid, Out_data
  );
endinterface

// File: rtl/sample_packer.sv
// sample_packer: packs up to three 10-bit samples plus a count into a 32-bit word
module sample_packer #(
  parameter logic [7:0] FLUSH_TIMEOUT = 8'd16
) (
  input logic            Clk,
  input logic            Rst_n,
  sample_packer_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FILL, CLOSED} state_t;
  state_t      state;
  logic [1:0]  cnt;
  logic [29:0] slots;
  logic [7:0]  idle;
  logic        out_valid;
  logic [31:0] out_data;
  logic        accept;
  logic        load;
  logic        timeout;
  assign bus.In_ready  = Rst_n && state != CLOSED;
  assign bus.Out_valid = out_valid;
  assign bus.Out_data  = out_data;
  assign accept  = bus.In_valid && bus.In_ready;
  assign load    = state == CLOSED && (!out_valid || bus.Out_ready);
  assign timeout = state == FILL && FLUSH_TIMEOUT != 8'd0 && idle == FLUSH_TIMEOUT;
  // an accept outranks a timeout expiring in the same cycle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= EMPTY;
      cnt       <= '0;
      slots     <= '0;
      idle      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (load) begin
        state <= EMPTY;
        cnt   <= '0;
        slots <= '0;
      end else if (accept) begin
        state <= (bus.In_last || cnt == 2'd2) ? CLOSED : FILL;
        cnt   <= cnt + 2'd1;
        if (cnt == 2'd0) slots[9:0]   <= bus.In_data;
        if (cnt == 2'd1) slots[19:10] <= bus.In_data;
        if (cnt == 2'd2) slots[29:20] <= bus.In_data;
      end else if (timeout) begin
        state <= CLOSED;
      end
      idle      <= (state != FILL || accept || timeout) ? 8'd0 : (idle == FLUSH_TIMEOUT ? idle : idle + 8'd1);
      out_valid <= load || (out_valid && !bus.Out_ready);
      if (load) out_data <= {slots, cnt};
    end
  end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed and random scoreboard checks of sample_packer
module tb_sample_packer;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  sample_packer_if bus();
  sample_packer #(.FLUSH_TIMEOUT(8'd4)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;
  int words_seen = 0;
  int acc_cnt = 0;
  int w0;
  int a0;
  bit done = 1'b0;
  logic [9:0]  samp_q[$];
  logic [31:0] word_q[$];
  logic [1:0]  mc;
  logic [9:0]  ms;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pk(input logic [1:0] c, input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2);
    return {s2, s1, s0, c};
  endfunction

  task automatic send(input logic [9:0] d, input logic l);
    int n = 0;
    @(negedge Clk);
    bus.In_valid = 1'b1;
    bus.In_data  = d;
    bus.In_last  = l;
    #1;
    while (!bus.In_ready && n < 200) begin
      @(negedge Clk);
      #1;
      n++;
    end
    chk("send_accepted", 32'(bus.In_ready), 1);
    if (bus.In_ready) begin
      samp_q.push_back(d);
      acc_cnt++;
    end
    @(posedge Clk);
    #1;
    bus.In_valid = 1'b0;
    bus.In_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((samp_q.size() != 0 || word_q.size() != 0) && n < 300) begin
      @(posedge Clk);
      n++;
    end
    chk("drain_queues_empty", 32'(samp_q.size() + word_q.size()), 0);
    repeat (2) @(posedge Clk);
  endtask

  // a word transfers at the next rising edge when valid and ready are both high here
  initial forever begin
    @(negedge Clk);
    #1;
    if (Rst_n && bus.Out_valid && bus.Out_ready) begin
      words_seen++;
      mc = bus.Out_data[1:0];
      chk("word_count_nonzero", 32'(mc != 2'd0), 1);
      for (int i = 0; i < 3; i++) begin
        ms = bus.Out_data[2 + 10*i +: 10];
        if (i < int'(mc)) begin
          chk("slot_has_expected", 32'(samp_q.size() != 0), 1);
          if (samp_q.size() != 0) chk("slot_order", 32'(ms), 32'(samp_q.pop_front()));
        end else begin
          chk("slot_unused_zero", 32'(ms), 0);
        end
      end
      if (word_q.size() != 0) chk("word", bus.Out_data, word_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.In_valid  = 1'b0;
    bus.In_data   = '0;
    bus.In_last   = 1'b0;
    bus.Out_ready = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst_in_ready", 32'(bus.In_ready), 0);
    chk("rst_out_valid", 32'(bus.Out_valid), 0);
    chk("rst_out_data", bus.Out_data, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(bus.In_ready), 1);

    bus.Out_ready = 1'b1;
    word_q.push_back(32'h00C02007);
    send(10'h001, 1'b0);
    send(10'h002, 1'b0);
    send(10'h003, 1'b0);
    chk("full_in_ready_low", 32'(bus.In_ready), 0);
    chk("full_valid_not_yet", 32'(bus.Out_valid), 0);
    @(posedge Clk);
    #1;
    chk("full_valid", 32'(bus.Out_valid), 1);
    chk("full_data", bus.Out_data, 32'h00C02007);
    chk("full_in_ready_back", 32'(bus.In_ready), 1);
    @(posedge Clk);
    #1;
    chk("full_valid_drop", 32'(bus.Out_valid), 0);
    drain();

    word_q.push_back(32'h00155FFE);
    send(10'h3FF, 1'b0);
    send(10'h155, 1'b1);
    drain();

    w0 = words_seen;
    word_q.push_back(32'h000002A9);
    send(10'h0AA, 1'b0);
    repeat (5) @(posedge Clk);
    #1;
    chk("timeout_no_early_flush", 32'(bus.Out_valid), 0);
    @(posedge Clk);
    #1;
    chk("timeout_flush_valid", 32'(bus.Out_valid), 1);
    chk("timeout_flush_data", bus.Out_data, 32'h000002A9);
    repeat (20) @(posedge Clk);
    chk("timeout_single_word", 32'(words_seen), 32'(w0 + 1));

    word_q.push_back(pk(2'd3, 10'h011, 10'h022, 10'h033));
    send(10'h011, 1'b0);
    repeat (4) @(posedge Clk);
    send(10'h022, 1'b0);
    send(10'h033, 1'b1);
    drain();

    @(negedge Clk);
    bus.Out_ready = 1'b0;
    a0 = acc_cnt;
    for (int w = 0; w < 3; w++) word_q.push_back(pk(2'd3, 10'(256 + 3*w), 10'(257 + 3*w), 10'(258 + 3*w)));
    fork
      begin
        for (int i = 0; i < 9; i++) send(10'(256 + i), 1'b0);
      end
      begin
        repeat (10) @(posedge Clk);
        #1;
        chk("stall_data_mid", bus.Out_data, pk(2'd3, 10'h100, 10'h101, 10'h102));
        repeat (10) @(posedge Clk);
        #1;
        chk("stall_data_end", bus.Out_data, pk(2'd3, 10'h100, 10'h101, 10'h102));
        chk("stall_valid", 32'(bus.Out_valid), 1);
        chk("stall_in_ready", 32'(bus.In_ready), 0);
        chk("stall_accepted", 32'(acc_cnt - a0), 6);
        @(negedge Clk);
        bus.Out_ready = 1'b1;
      end
    join
    drain();

    @(negedge Clk);
    bus.Out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(10'(80 + i), 1'b0);
    chk("pre_reset_valid", 32'(bus.Out_valid), 1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus.Out_valid), 0);
    chk("reset_out_data", bus.Out_data, 0);
    chk("reset_in_ready", 32'(bus.In_ready), 0);
    samp_q.delete();
    word_q.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    bus.Out_ready = 1'b1;
    w0 = words_seen;
    word_q.push_back(pk(2'd3, 10'h060, 10'h061, 10'h062));
    send(10'h060, 1'b0);
    send(10'h061, 1'b0);
    send(10'h062, 1'b0);
    drain();
    chk("reset_single_clean_word", 32'(words_seen), 32'(w0 + 1));

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat (($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 1)) @(posedge Clk);
          send(10'($urandom_range(0, 1023)), $urandom_range(0, 7) == 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge Clk);
          bus.Out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge Clk);
    bus.Out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 The module SHALL have one parameter: FLUSH_TIMEOUT, default 16, the number of consecutive idle cycles before a partial word is flushed (8-bit range; 0 disables timeout flush).
REQ-002 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 In_valid  input  1  upstream sample valid.
REQ-005 In_ready  output  1  packer accepts a sample this cycle.
REQ-006 In_data  input  10  sample value.
REQ-007 In_last  input  1  qualified by In_valid; the accepted sample closes the current word.
REQ-008 Out_valid  output  1  packed word available to the downstream ping-pong buffer.
REQ-009 Out_ready  input  1  downstream accepts the word.
REQ-010 Out_data  output  32  packed word: [1:0] sample count (1..3), [11:2] slot 0, [21:12] slot 1, [31:22] slot 2; unused slots zero.

Function
REQ-011 A sample SHALL transfer only in cycles with In_valid=1 and In_ready=1, and a word only in cycles with Out_valid=1 and Out_ready=1.
REQ-012 Accepted samples SHALL fill slots in arrival order: first sample to slot 0, second to slot 1, third to slot 2.
REQ-013 The accumulator SHALL have three states: EMPTY (count 0), FILL (count 1..2, open), CLOSED (word complete, awaiting transfer to output register).
REQ-014 EMPTY->FILL on an accept without In_last; EMPTY->CLOSED on an accept with In_last.
REQ-015 FILL->CLOSED on an accept that makes count 3, an accept with In_last, or timeout expiry; FILL->FILL otherwise.
REQ-016 In_ready SHALL be 1 in EMPTY and FILL and 0 in CLOSED, independent of Out_ready.
REQ-017 In CLOSED, when Out_valid=0 or Out_ready=1, the word SHALL load into the output register at that edge, the accumulator SHALL clear to EMPTY, and Out_valid SHALL be 1 the next cycle.
REQ-018 In CLOSED with Out_valid=1 and Out_ready=0, the accumulator SHALL hold unchanged.
REQ-019 Latency: Out_valid SHALL rise 2 cycles after the closing accept when the output register is free; sustained throughput SHALL be 3 samples per 4 cycles.
REQ-020 Out_data SHALL stay stable while Out_valid=1 and Out_ready=0; Out_valid SHALL drop after the accepting cycle unless a new word loads at the same edge.
REQ-021 The idle counter SHALL increment each cycle in FILL with no accept, clear on any accept or on leaving FILL, and saturate at FLUSH_TIMEOUT.
REQ-022 When the idle counter equals FLUSH_TIMEOUT (nonzero) in FILL, the state SHALL become CLOSED at that edge.
REQ-023 With FLUSH_TIMEOUT=0, partial words SHALL flush only via In_last.
REQ-024 A word with count 0 SHALL never be emitted; In_last without In_valid SHALL be ignored.
REQ-025 A timeout expiring in the same cycle as an accept SHALL be ignored; the accept takes effect and the counter clears.

Reset
REQ-026 While Rst_n=0: state EMPTY, accumulator and slots zero, idle counter zero, Out_valid=0, Out_data=0, In_ready=0.
REQ-027 In_ready SHALL be 1 in the first cycle after Rst_n deasserts.
REQ-028 Reset asserted mid-word or with Out_valid=1 SHALL discard all pending samples and the pending word, with no partial word emitted after release.

Verification
REQ-029 Out_ready=1, samples 0x001, 0x002, 0x003 back-to-back -> Out_data=0x00C02007, Out_valid high 2 cycles after the third accept, In_ready low for exactly 1 cycle.
REQ-030 Samples 0x3FF, then 0x155 with In_last -> Out_data=0x00155FFE (count 2, slot 2 zero).
REQ-031 FLUSH_TIMEOUT=4, single sample 0x0AA then idle -> Out_data=0x000002A9 after 4 idle cycles; no further words emitted.
REQ-032 Out_ready=0 for 20 cycles while 9 samples are offered -> first word held stable, second word closed and stalled, In_ready=0, only 6 samples accepted; on Out_ready=1, words drain in order with no loss or duplication.
REQ-033 Assert Rst_n=0 with 2 samples accumulated and a word pending -> Out_valid=0 immediately; after release, the next 3 samples produce a single clean count-3 word.
REQ-034 Random valid/ready stall patterns, 1000 samples with random In_last -> scoreboard: concatenated unpacked output slots equal the input sequence, and every count field is between 1 and 3.
